// File: rtl/sub_unit.sv
// Registered subtractor: SUBOut = DOut2 - DOut1 (mod 2^WIDTH) with borrow/zero/neg/ovf flags,
// all captured one clock after a valid operand pair.
module sub_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] DOut2,
  input  logic [WIDTH-1:0] DOut1,
  output logic [WIDTH-1:0] SUBOut,
  output logic             out_valid,
  output logic             borrow,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  logic [WIDTH:0]   w_diff;
  logic [WIDTH-1:0] w_sub;
  logic             w_borrow;
  logic             w_zero;
  logic             w_neg;
  logic             w_ovf;

  logic [WIDTH-1:0] r_sub;
  logic             r_valid;
  logic             r_borrow;
  logic             r_zero;
  logic             r_neg;
  logic             r_ovf;

  // Form the difference and its flags from the current operands.
  always_comb begin
    w_diff   = {1'b0, DOut2} - {1'b0, DOut1};
    w_sub    = w_diff[WIDTH-1:0];
    w_borrow = w_diff[WIDTH];
    w_zero   = (w_sub == '0);
    w_neg    = w_sub[WIDTH-1];
    // Overflow only when operand signs differ and the result sign departs from the minuend.
    w_ovf    = (DOut2[WIDTH-1] != DOut1[WIDTH-1]) && (w_sub[WIDTH-1] != DOut2[WIDTH-1]);
  end

  // Capture result and flags on a valid pair; hold them otherwise. Valid is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub    <= '0;
      r_valid  <= 1'b0;
      r_borrow <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_valid <= in_valid;
      if (in_valid) begin
        r_sub    <= w_sub;
        r_borrow <= w_borrow;
        r_zero   <= w_zero;
        r_neg    <= w_neg;
        r_ovf    <= w_ovf;
      end
    end
  end

  // Outputs come straight from registers; no combinational input-to-output path.
  always_comb begin
    SUBOut    = r_sub;
    out_valid = r_valid;
    borrow    = r_borrow;
    zero      = r_zero;
    neg       = r_neg;
    ovf       = r_ovf;
  end

endmodule

// File: tb/tb_sub_unit.sv
// Directed self-checking bench for sub_unit (WIDTH = 8).
// Flags are compared as the packed vector {out_valid, borrow, zero, neg, ovf}.
module tb_sub_unit;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] DOut2;
  logic [W-1:0] DOut1;
  logic [W-1:0] SUBOut;
  logic         out_valid;
  logic         borrow;
  logic         zero;
  logic         neg;
  logic         ovf;

  int n_assert = 0;
  int n_fail   = 0;

  sub_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .DOut2     (DOut2),
    .DOut1     (DOut1),
    .SUBOut    (SUBOut),
    .out_valid (out_valid),
    .borrow    (borrow),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_assert++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic check_out(input string tag, input logic [W-1:0] exp_sub, input logic [4:0] exp_flags);
    check({tag, ".sub"}, {24'd0, SUBOut}, {24'd0, exp_sub});
    check({tag, ".flags"}, {27'd0, out_valid, borrow, zero, neg, ovf}, {27'd0, exp_flags});
  endtask

  // Drive a pair at the falling edge, then sample #1 after the capturing rising edge.
  task automatic apply(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    DOut2    = a;
    DOut1    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    DOut2    = 8'd7;
    DOut1    = 8'd7;
    #1;
    check_out("reset_now", 8'h00, 5'b00000);
    @(posedge clk); @(posedge clk); #1;
    check_out("reset_held", 8'h00, 5'b00000);

    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk); #1;
    check_out("post_reset_idle", 8'h00, 5'b00000);

    apply(8'd7, 8'd7);
    check_out("eq_7_7", 8'h00, 5'b10100);
    apply(8'd10, 8'd10);
    check_out("eq_10_10", 8'h00, 5'b10100);
    apply(8'd3, 8'd7);
    check_out("wrap_3_7", 8'hFC, 5'b11010);
    apply(8'd9, 8'd10);
    check_out("wrap_9_10", 8'hFF, 5'b11010);
    apply(8'd3, 8'd1);
    check_out("sub_3_1", 8'h02, 5'b10000);
    apply(8'd9, 8'd1);
    check_out("sub_9_1", 8'h08, 5'b10000);
    apply(8'h80, 8'h01);
    check_out("ovf_80_01", 8'h7F, 5'b10001);
    apply(8'h7F, 8'hFF);
    check_out("ovf_7F_FF", 8'h80, 5'b11011);

    // Back-to-back stream, then idle with junk operands: result and flags must hold.
    apply(8'h40, 8'h40);
    check_out("stream0", 8'h00, 5'b10100);
    apply(8'h20, 8'h10);
    check_out("stream1", 8'h10, 5'b10000);
    apply(8'h05, 8'h06);
    check_out("stream2", 8'hFF, 5'b11010);
    @(negedge clk);
    in_valid = 1'b0;
    DOut2    = 'x;
    DOut1    = 'x;
    @(posedge clk); #1;
    check_out("idle_hold", 8'hFF, 5'b01010);
    @(posedge clk); #1;
    check_out("idle_hold2", 8'hFF, 5'b01010);

    // Asynchronous reset between edges with a valid pair in flight.
    @(negedge clk);
    in_valid = 1'b1;
    DOut2    = 8'd7;
    DOut1    = 8'd7;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 8'h00, 5'b00000);
    @(posedge clk); #1;
    check_out("reset_inflight", 8'h00, 5'b00000);

    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("release_idle", 8'h00, 5'b00000);
    apply(8'd3, 8'd7);
    check_out("first_after_reset", 8'hFC, 5'b11010);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check_out("pulse_end", 8'hFC, 5'b01010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
